// File: rtl/alu_pkg.sv
// Shared types for the ARM-style ALU: opcode encoding, datapath width, flag bundle.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_adder.sv
// WIDTH+1-bit adder: sum, carry-out of the top bit and signed overflow of x+y+carry_in.
module alu_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH:0] w_full;

  assign w_full    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};
  assign sum       = w_full[WIDTH-1:0];
  assign carry_out = w_full[WIDTH];
  // Overflow: like-signed inputs producing a result of the other sign.
  assign overflow  = (x[WIDTH-1] == y[WIDTH-1]) && (w_full[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/arm_alu.sv
// ARM-style 16-op data-processing ALU with registered result and NZCV flags (1-cycle latency).
// Optional ALU_STICKY_V_EN adds v_sticky, a reset-cleared latch of any registered overflow.
module arm_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
`ifdef ALU_STICKY_V_EN
  ,
  output logic             v_sticky
`endif
);

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ci;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic             w_ov;
  logic             w_arith;
  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_flags;

  logic [WIDTH-1:0] r_s;
  alu_flags_t       r_flags;

  assign w_op = alu_op_e'(op);

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .x         (w_x),
    .y         (w_y),
    .carry_in  (w_ci),
    .sum       (w_sum),
    .carry_out (w_co),
    .overflow  (w_ov)
  );

  // Subtracts swap/invert operands so the single adder covers every arithmetic op.
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_ci    = 1'b0;
    w_arith = 1'b0;
    w_res   = '0;
    case (w_op)
      OP_AND, OP_TST: w_res = a & b;
      OP_EOR, OP_TEQ: w_res = a ^ b;
      OP_ORR:         w_res = a | b;
      OP_MOV:         w_res = b;
      OP_BIC:         w_res = a & ~b;
      OP_MVN:         w_res = ~b;
      OP_SUB, OP_CMP: begin
        w_y = ~b; w_ci = 1'b1; w_arith = 1'b1; w_res = w_sum;
      end
      OP_RSB: begin
        w_x = b; w_y = ~a; w_ci = 1'b1; w_arith = 1'b1; w_res = w_sum;
      end
      OP_ADD, OP_CMN: begin
        w_arith = 1'b1; w_res = w_sum;
      end
      OP_ADC: begin
        w_ci = cin; w_arith = 1'b1; w_res = w_sum;
      end
      OP_SBC: begin
        w_y = ~b; w_ci = cin; w_arith = 1'b1; w_res = w_sum;
      end
      OP_RSC: begin
        w_x = b; w_y = ~a; w_ci = cin; w_arith = 1'b1; w_res = w_sum;
      end
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_flags.n = w_res[WIDTH-1];
    w_flags.z = (w_res == '0);
    w_flags.c = w_arith ? w_co : cin;
    w_flags.v = w_arith ? w_ov : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s     <= '0;
      r_flags <= '0;
    end else begin
      r_s     <= w_res;
      r_flags <= w_flags;
    end
  end

  assign s = r_s;
  assign n = r_flags.n;
  assign z = r_flags.z;
  assign c = r_flags.c;
  assign v = r_flags.v;

`ifdef ALU_STICKY_V_EN
  logic r_v_sticky;

  always_ff @(posedge clk) begin
    if (reset) r_v_sticky <= 1'b0;
    else       r_v_sticky <= r_v_sticky | w_flags.v;
  end

  assign v_sticky = r_v_sticky;
`endif

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed literal vectors plus randomized ops against an arithmetic model.
module tb_arm_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        cin;
  logic [31:0] s;
  logic        n, z, c, v;
`ifdef ALU_STICKY_V_EN
  logic        v_sticky;
  logic        exp_sticky = 1'b0;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [35:0] exp_q;
  logic        exp_valid = 1'b0;

  always #5 clk = ~clk;

  arm_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .op    (op),
    .cin   (cin),
    .s     (s),
    .n     (n),
    .z     (z),
    .c     (c),
    .v     (v)
`ifdef ALU_STICKY_V_EN
    ,
    .v_sticky (v_sticky)
`endif
  );

  // Model: exact integer arithmetic in 64 bits; carry = no unsigned wrap/borrow, V = signed range exceeded.
  function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                        input logic ci);
    longint      up, uq, sp, sq, ur, sr, k;
    logic [31:0] r;
    logic        cf, vf;
    cf = ci;
    vf = 1'b0;
    r  = '0;
    k  = ci ? 1 : 0;
    up = longint'(xa); uq = longint'(xb);
    sp = longint'($signed(xa)); sq = longint'($signed(xb));
    if (o == 4'd3 || o == 4'd7) begin
      up = longint'(xb); uq = longint'(xa);
      sp = longint'($signed(xb)); sq = longint'($signed(xa));
    end
    case (o)
      4'd0, 4'd8:  r = xa & xb;
      4'd1, 4'd9:  r = xa ^ xb;
      4'd12:       r = xa | xb;
      4'd13:       r = xb;
      4'd14:       r = xa & ~xb;
      4'd15:       r = ~xb;
      4'd4, 4'd11, 4'd5: begin
        if (o != 4'd5) k = 0;
        ur = up + uq + k;
        sr = sp + sq + k;
        r  = ur[31:0];
        cf = (ur > 64'sd4294967295);
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: begin
        if (o == 4'd2 || o == 4'd3 || o == 4'd10) k = 1;
        ur = up - uq - (1 - k);
        sr = sp - sq - (1 - k);
        r  = ur[31:0];
        cf = (ur >= 0);
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
    endcase
    return {r, r[31], (r == 32'd0), cf, vf};
  endfunction

  always @(posedge clk) begin
    if (reset) exp_q = '0;
    else       exp_q = model(op, a, b, cin);
`ifdef ALU_STICKY_V_EN
    if (reset) exp_sticky = 1'b0;
    else       exp_sticky = exp_sticky | exp_q[0];
`endif
    exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      n_total++;
      if ({s, n, z, c, v} !== exp_q) begin
        n_bad++;
        $display("FAIL model t=%0t: got s=%h nzcv=%b%b%b%b, want s=%h nzcv=%b",
                 $time, s, n, z, c, v, exp_q[35:4], exp_q[3:0]);
      end
`ifdef ALU_STICKY_V_EN
      n_total++;
      if (v_sticky !== exp_sticky) begin
        n_bad++;
        $display("FAIL sticky t=%0t: got %b want %b", $time, v_sticky, exp_sticky);
      end
`endif
    end
  end

  task automatic drive(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic xc, input logic rst);
    @(negedge clk);
    op = o; a = xa; b = xb; cin = xc; reset = rst;
  endtask

  task automatic expect_lit(input string nm, input logic [31:0] es, input logic [3:0] ef);
    @(posedge clk);
    #1;
    n_total++;
    if ({s, n, z, c, v} !== {es, ef}) begin
      n_bad++;
      $display("FAIL %s: got s=%h nzcv=%b%b%b%b, want s=%h nzcv=%b", nm, s, n, z, c, v, es, ef);
    end
  endtask

  logic [31:0] sw_s [16];
  logic [3:0]  sw_f [16];
  logic [31:0] pick [8];

  initial begin
    reset = 1'b1; op = 4'd0; a = '0; b = '0; cin = 1'b0;
    sw_s = '{32'd0, 32'd6, 32'd2, 32'hFFFFFFFE, 32'd6, 32'd6, 32'd1, 32'hFFFFFFFD,
             32'd0, 32'd6, 32'd2, 32'd6, 32'd6, 32'd2, 32'd4, 32'hFFFFFFFD};
    sw_f = '{4'b0100, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b1000,
             4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    pick = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001,
             32'h7FFFFFFE, 32'h55555555};

    drive(4'd4, 32'h12345678, 32'h1, 1'b1, 1'b1);
    expect_lit("reset_state", 32'd0, 4'b0000);

    drive(4'd4, 32'h7FFFFFFF, 32'h00000800, 1'b0, 1'b0);
    expect_lit("add_overflow", 32'h800007FF, 4'b1001);
    drive(4'd2, 32'h80000001, 32'h400E0800, 1'b0, 1'b0);
    expect_lit("sub_overflow", 32'h3FF1F801, 4'b0011);

    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        drive(4'(i), 32'd4, 32'd2, 1'b0, 1'b1);
        expect_lit("sweep_reset", 32'd0, 4'b0000);
      end
      drive(4'(i), 32'd4, 32'd2, 1'b0, 1'b0);
      expect_lit($sformatf("sweep_op%0d", i), sw_s[i], sw_f[i]);
    end

    drive(4'd5, 32'd4, 32'd2, 1'b1, 1'b0);
    expect_lit("adc_cin", 32'd7, 4'b0000);
    drive(4'd6, 32'd4, 32'd2, 1'b1, 1'b0);
    expect_lit("sbc_cin", 32'd2, 4'b0010);
    drive(4'd7, 32'd4, 32'd2, 1'b1, 1'b0);
    expect_lit("rsc_cin", 32'hFFFFFFFE, 4'b1000);
    drive(4'd12, 32'd4, 32'd2, 1'b1, 1'b0);
    expect_lit("orr_cin_pass", 32'd6, 4'b0010);

    drive(4'd4, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    expect_lit("add_carry_zero", 32'd0, 4'b0110);
    drive(4'd10, 32'd5, 32'd5, 1'b0, 1'b0);
    expect_lit("cmp_equal", 32'd0, 4'b0110);

    for (int i = 0; i < 3000; i++) begin
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 7)] : $urandom(),
            ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 7)] : $urandom(),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end

    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
